ysyx_imem_responder: RTL and testbench
======================================

// Module: ysyx_imem_responder
// PURPOSE
//  Responder end of the IFU instruction-fetch read channel (araddr/arvalid -> rdata/rvalid).
//  Word-addressed instruction memory with programmable (optionally jittered) response latency.
//  Used as the fetch target in sim/SoC-less builds and as the IFU bench partner.
//  Exactly one response per accepted request; requests held across responses are not re-served.
// PARAMETERS
//  ADDR_W     32            address width
//  DATA_W     32            data width (word = DATA_W bits)
//  DEPTH      4096          memory words; index = (araddr-BASE_ADDR)>>2
//  BASE_ADDR  32'h80000000  first mapped byte address
//  LATENCY    2             cycles from request accept to rvalid, >=1
//  RAND_LAT   0             1: add lfsr[1:0] (0..3) extra cycles per request
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  arvalid    in   1       fetch request valid (level, held by requester)
//  araddr     in   ADDR_W  fetch byte address
//  arready    out  1       1 only in IDLE
//  rvalid     out  1       one-cycle response pulse
//  rdata      out  DATA_W  fetched word; 0 when rvalid=0 or on error
//  rresp      out  2       00 OKAY, 10 misaligned, 11 unmapped; 00 when rvalid=0
//  ld_we      in   1       bench/loader write enable (any state)
//  ld_idx     in   $clog2(DEPTH)  word index to write
//  ld_data    in   DATA_W  word to write
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rvalid=0, rdata=0, rresp=00, cnt=0, lfsr=8'h5A; array untouched.
//  States: IDLE -> WAIT -> RESP -> HOLD -> IDLE.
//  IDLE: arready=1. On arvalid: capture addr, word=mem[idx] (or 0 on error), resp code;
//        cnt <= LATENCY-1 + (RAND_LAT ? lfsr[1:0] : 0); go WAIT (or RESP if cnt would be 0).
//  WAIT: cnt decrements each cycle; at cnt==0 go RESP. arvalid/araddr ignored.
//  RESP: rvalid=1, rdata/rresp = captured values, exactly one cycle; go HOLD.
//  HOLD: return to IDLE when arvalid=0 OR araddr != captured addr (same cycle the change is
//        seen); new request is accepted in IDLE next cycle. Same addr held -> no second response.
//  Latency: accept edge at cycle T -> rvalid high during cycle T+LATENCY(+jitter).
//  Errors: araddr[1:0]!=0 -> rresp=10; addr<BASE or idx>=DEPTH -> 11 (unmapped wins over
//        misaligned); rdata=0 in both; array never read.
//  Range check done on full ADDR_W width (no wrap of addr-BASE).
//  Data snapshot taken at accept; ld_we writes after accept do not alter in-flight data.
//  ld_we same cycle as accept to same idx: response returns the OLD word.
//  lfsr: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle out of reset.
//  Reset mid-WAIT/RESP: pending response dropped, no rvalid after release.
// TESTING
//  LATENCY=2, ld mem[0]=0x00000413; arvalid, araddr=0x80000000 accepted T -> rvalid at T+2, rdata=0x00000413, rresp=00.
//  Hold arvalid, same addr 20 cycles -> exactly one rvalid pulse; change addr to 0x80000004 -> second pulse 0x..., from IDLE+2.
//  araddr=0x80000002 -> rvalid with rresp=10, rdata=0; araddr=0x7FFFFFFC and BASE+4*DEPTH -> rresp=11.
//  Assert rst=0 one cycle after accept -> rvalid never asserts; post-release request served normally.
//  ld_we to idx 5 with value 0xDEADBEEF at accept of idx 5 (old 0x1) -> rdata=0x1; next fetch -> 0xDEADBEEF.
//  RAND_LAT=1, 1000 requests -> every latency in [2,5], all four values observed.

Source files
------------

// File: rtl/ysyx_imem_responder.sv
// ysyx_imem_responder: responder end of the IFU instruction-fetch read channel.
// Word-addressed instruction memory with a programmable response latency and
// optional LFSR jitter. Each accepted request gets exactly one response. A request
// that is still held with the same address after its response is not served again.
module ysyx_imem_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                LATENCY   = 2,
  parameter int                RAND_LAT  = 0,
  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arvalid,
  input  logic [ADDR_W-1:0] araddr,
  output logic              arready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  input  logic              ld_we,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int              WA_W   = ADDR_W - 2;
  localparam int              CNT_W  = $clog2(LATENCY + 4) + 1;
  localparam logic [WA_W-1:0] BASE_W = BASE_ADDR[ADDR_W-1:2];

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_MISALIGN = 2'b10;
  localparam logic [1:0] RESP_UNMAPPED = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   word_q;
  logic [1:0]          resp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          lfsr_q;
  logic                arready_q;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;

  logic [WA_W-1:0]     wa;
  logic [WA_W-1:0]     delta;
  logic                unmapped;
  logic                misal;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          resp_d;
  logic [DATA_W-1:0]   word_d;
  logic [CNT_W-1:0]    cnt_d;

  // Decode the incoming address; the range test is done on word addresses so
  // addr-BASE can never wrap, and unmapped takes priority over misaligned.
  always_comb begin
    wa       = araddr[ADDR_W-1:2];
    delta    = wa - BASE_W;
    unmapped = (wa < BASE_W) || (delta >= WA_W'(DEPTH));
    misal    = (araddr[1:0] != 2'b00);
    idx      = delta[IDX_W-1:0];
    if (unmapped) begin
      resp_d = RESP_UNMAPPED;
    end else if (misal) begin
      resp_d = RESP_MISALIGN;
    end else begin
      resp_d = RESP_OKAY;
    end
    word_d = (resp_d == RESP_OKAY) ? mem[idx] : '0;
    cnt_d  = CNT_W'(LATENCY - 1) + ((RAND_LAT != 0) ? CNT_W'(lfsr_q[1:0]) : '0);
  end

  // Loader write port; the array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used for latency jitter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 8'h5A;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Request/response FSM with registered channel outputs; the word is snapshot at
  // accept so later loader writes cannot disturb an in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      cnt_q     <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arvalid) begin
            addr_q    <= araddr;
            word_q    <= word_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
            arready_q <= 1'b0;
            if (cnt_d == '0) begin
              state_q  <= S_RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= word_d;
              rresp_q  <= resp_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_q  <= S_RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= word_q;
            rresp_q  <= resp_q;
          end
        end
        S_RESP: begin
          state_q  <= S_HOLD;
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          rresp_q  <= RESP_OKAY;
        end
        S_HOLD: begin
          if (!arvalid || (araddr != addr_q)) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rdata_q   <= '0;
          rresp_q   <= RESP_OKAY;
        end
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_imem_responder.sv
// Self-checking bench for ysyx_imem_responder: fixed-latency instance for data,
// error codes, hold/reset/loader corner cases; jittered instance for latency spread.
module tb_ysyx_imem_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH0 = 4096;
  localparam int          DEPTH1 = 64;
  localparam int          LAT    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        av0 = 1'b0;
  logic [31:0] aa0 = '0;
  logic        ar0, rv0;
  logic [31:0] rd0;
  logic [1:0]  rr0;
  logic        ldwe0 = 1'b0;
  logic [11:0] ldidx0 = '0;
  logic [31:0] lddata0 = '0;

  logic        av1 = 1'b0;
  logic [31:0] aa1 = '0;
  logic        ar1, rv1;
  logic [31:0] rd1;
  logic [1:0]  rr1;
  logic        ldwe1 = 1'b0;
  logic [5:0]  ldidx1 = '0;
  logic [31:0] lddata1 = '0;

  int          checks = 0;
  int          errors = 0;
  int          ecnt;
  logic [31:0] mm [DEPTH0];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] d;
    logic [1:0]  r;
  } vec_t;
  vec_t tbl [9];

  ysyx_imem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH0), .BASE_ADDR(BASE),
                        .LATENCY(LAT), .RAND_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .arvalid(av0), .araddr(aa0), .arready(ar0), .rvalid(rv0),
    .rdata(rd0), .rresp(rr0), .ld_we(ldwe0), .ld_idx(ldidx0), .ld_data(lddata0));

  ysyx_imem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH1), .BASE_ADDR(BASE),
                        .LATENCY(LAT), .RAND_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .arvalid(av1), .araddr(aa1), .arready(ar1), .rvalid(rv1),
    .rdata(rd1), .rresp(rr1), .ld_we(ldwe1), .ld_idx(ldidx1), .ld_data(lddata1));

  always #5 clk = ~clk;

  // clock edges since reset release; the LFSR has advanced once per edge
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_at(input int k);
    logic [7:0] s;
    s = 8'h5A;
    for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    if (a < BASE) return 2'b11;
    if ((a - BASE) >= 32'(4 * DEPTH0)) return 2'b11;
    if (a[1:0] != 2'b00) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a);
    if (m_resp(a) != 2'b00) return 32'h0;
    return mm[(a - BASE) / 4];
  endfunction

  function automatic int pick_idx();
    int p;
    p = int'($urandom % 64);
    return (p < 32) ? p : (4064 + p - 32);
  endfunction

  task automatic ld0(input int idx, input logic [31:0] v);
    ldwe0 = 1'b1; ldidx0 = 12'(idx); lddata0 = v;
    tick();
    ldwe0 = 1'b0;
    mm[idx] = v;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (!ar0 && n < 50) begin tick(); n++; end
    chk("arready_wait0", ar0, 1);
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while (!ar1 && n < 50) begin tick(); n++; end
    chk("arready_wait1", ar1, 1);
  endtask

  // one request on dut0; optional loader write on the accept edge
  task automatic req0(input logic [31:0] a, input bit do_ld, input int li, input logic [31:0] lv,
                      output logic [31:0] d, output logic [1:0] r, output int lat);
    bit noisy;
    wait_idle0();
    av0 = 1'b1; aa0 = a;
    if (do_ld) begin ldwe0 = 1'b1; ldidx0 = 12'(li); lddata0 = lv; end
    tick();
    ldwe0 = 1'b0;
    chk("arready_busy", ar0, 0);
    lat = 1; noisy = 1'b0;
    while (!rv0 && lat < 20) begin
      if (rd0 != 0 || rr0 != 0) noisy = 1'b1;
      tick(); lat++;
    end
    chk("quiet_wait", noisy, 0);
    d = rd0; r = rr0;
  endtask

  // keep arvalid for n more edges after the pulse, then drop it
  task automatic finish0(input int n);
    int extra;
    extra = 0;
    repeat (n + 1) begin tick(); if (rv0) extra++; end
    av0 = 1'b0;
    tick();
    chk("no_second_pulse", extra, 0);
    chk("hold_exit", ar0, 1);
  endtask

  initial begin
    logic [31:0] d, ed, lv;
    logic [1:0]  r, er;
    int          lat, n, cnt, kind, idx, li, k;
    bit          do_ld;
    int          hist [4];
    logic [31:0] a;

    for (int i = 0; i < DEPTH0; i++) mm[i] = '0;
    for (int i = 0; i < 4; i++) hist[i] = 0;

    #1 rst = 1'b0;
    repeat (3) tick();
    chk("rst_arready", ar0, 1);
    chk("rst_rvalid", rv0, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_rresp", rr0, 0);
    chk("rst_rvalid1", rv1, 0);
    chk("rst_arready1", ar1, 1);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) ld0(i, $urandom);
    for (int i = 4064; i < 4096; i++) ld0(i, $urandom);
    ld0(0, 32'h0000_0413);
    ld0(1, 32'h1234_5678);
    ld0(5, 32'h0000_0001);
    ld0(4095, 32'hCAFE_F00D);

    tbl[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00};
    tbl[1] = '{32'h8000_0004, 32'h1234_5678, 2'b00};
    tbl[2] = '{32'h8000_0002, 32'h0000_0000, 2'b10};
    tbl[3] = '{32'h7FFF_FFFC, 32'h0000_0000, 2'b11};
    tbl[4] = '{32'h8000_4000, 32'h0000_0000, 2'b11};
    tbl[5] = '{32'h8000_3FFC, 32'hCAFE_F00D, 2'b00};
    tbl[6] = '{32'h7FFF_FFFE, 32'h0000_0000, 2'b11};
    tbl[7] = '{32'h8000_4001, 32'h0000_0000, 2'b11};
    tbl[8] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b11};
    for (int i = 0; i < 9; i++) begin
      req0(tbl[i].addr, 1'b0, 0, 0, d, r, lat);
      chk("tbl_rdata", d, tbl[i].d);
      chk("tbl_rresp", r, tbl[i].r);
      chk("tbl_latency", lat, LAT);
      finish0(0);
    end

    // held request: one pulse only, then an address change is served from IDLE
    req0(BASE, 1'b0, 0, 0, d, r, lat);
    chk("hold_first_data", d, 32'h0000_0413);
    cnt = 0;
    repeat (20) begin tick(); if (rv0) cnt++; end
    chk("hold_pulses", cnt, 0);
    chk("hold_arready", ar0, 0);
    aa0 = BASE + 32'd4;
    n = 0;
    while (!rv0 && n < 20) begin tick(); n++; end
    chk("hold_change_latency", n, LAT + 1);
    chk("hold_change_data", rd0, 32'h1234_5678);
    finish0(0);

    // loader write while in flight does not alter the response
    wait_idle0();
    av0 = 1'b1; aa0 = BASE;
    tick();
    ldwe0 = 1'b1; ldidx0 = 12'd0; lddata0 = 32'h1111_1111;
    tick();
    ldwe0 = 1'b0;
    mm[0] = 32'h1111_1111;
    chk("inflight_rvalid", rv0, 1);
    chk("inflight_rdata", rd0, 32'h0000_0413);
    finish0(0);
    req0(BASE, 1'b0, 0, 0, d, r, lat);
    chk("after_write_rdata", d, 32'h1111_1111);
    finish0(0);

    // loader write on the accept edge: old word returned
    req0(BASE + 32'h14, 1'b1, 5, 32'hDEAD_BEEF, d, r, lat);
    mm[5] = 32'hDEAD_BEEF;
    chk("same_cycle_old", d, 32'h0000_0001);
    finish0(0);
    req0(BASE + 32'h14, 1'b0, 0, 0, d, r, lat);
    chk("same_cycle_new", d, 32'hDEAD_BEEF);
    finish0(0);

    // reset right after accept drops the pending response
    wait_idle0();
    av0 = 1'b1; aa0 = BASE + 32'd4;
    tick();
    chk("rst_mid_accepted", ar0, 0);
    rst = 1'b0; av0 = 1'b0;
    #1;
    chk("rst_mid_rvalid", rv0, 0);
    chk("rst_mid_arready", ar0, 1);
    tick();
    rst = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (rv0) cnt++; end
    chk("rst_mid_no_pulse", cnt, 0);
    req0(BASE + 32'd4, 1'b0, 0, 0, d, r, lat);
    chk("post_rst_rdata", d, 32'h1234_5678);
    chk("post_rst_latency", lat, LAT);
    finish0(0);

    // randomized traffic on the fixed-latency instance
    for (int it = 0; it < 300; it++) begin
      kind = int'($urandom % 6);
      idx = pick_idx();
      case (kind)
        0, 1, 2: a = BASE + 32'(4 * idx);
        3:       a = BASE + 32'(4 * idx) + 32'(1 + $urandom % 3);
        4:       a = $urandom % 32'h8000_0000;
        default: a = 32'h8000_4000 + ($urandom % 32'h7FFF_C000);
      endcase
      do_ld = ($urandom % 4) == 0;
      li = pick_idx();
      lv = $urandom;
      ed = m_data(a);
      er = m_resp(a);
      req0(a, do_ld, li, lv, d, r, lat);
      if (do_ld) mm[li] = lv;
      chk("rnd_rdata", d, ed);
      chk("rnd_rresp", r, er);
      chk("rnd_latency", lat, LAT);
      finish0(int'($urandom % 4));
    end

    // jittered instance: latency is LATENCY plus the LFSR's low bits at accept
    for (int it = 0; it < 1000; it++) begin
      wait_idle1();
      av1 = 1'b1; aa1 = BASE + 32'(4 * ($urandom % DEPTH1));
      tick();
      k = ecnt - 1;
      lat = 1;
      while (!rv1 && lat < 20) begin tick(); lat++; end
      chk("jit_latency", lat, LAT + int'(lfsr_at(k) & 8'h03));
      chk("jit_rresp", rr1, 0);
      if (lat >= 2 && lat <= 5) hist[lat - 2]++;
      av1 = 1'b0;
      tick();
      tick();
    end
    for (int v = 0; v < 4; v++) chk("jit_value_seen", hist[v] > 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
